// File: rtl/audio_timer_scheduler.sv
// Avalon-MM sequencer for the interval timer s1 port: programs the period, services timeout IRQs,
// and turns each serviced timeout into a system tick feeding a tick counter and countdown channels.
module audio_timer_scheduler #(
    parameter logic [31:0] PERIOD_DEFAULT = 32'd49999,
    parameter int unsigned NCH            = 4,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_start,
    input  logic             cfg_stop,
    input  logic [31:0]      cfg_period,
    output logic             busy,
    output logic             running,
    output logic [2:0]       tm_address,
    output logic             tm_chipselect,
    output logic             tm_write_n,
    output logic [15:0]      tm_writedata,
    input  logic             tm_irq,
    output logic             tick,
    output logic [31:0]      tick_count,
    input  logic [NCH-1:0]   ch_load,
    input  logic [CNT_W-1:0] ch_value,
    output logic [NCH-1:0]   ch_active,
    output logic [NCH-1:0]   ch_expire
);

    typedef enum logic [3:0] {
        StIdle, StWrPl, StWrPh, StWrCtl, StRun, StClr, StGuard, StWrStop, StStopClr
    } state_e;

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    state_e           state_q, state_d;
    logic [31:0]      period_q, period_d;
    logic             stop_pend_q, stop_pend_d;
    logic             start_acc;
    logic [31:0]      tick_count_q;
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [NCH-1:0]   active_q;
    logic [NCH-1:0]   expire_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            period_q     <= '0;
            stop_pend_q  <= 1'b0;
            tick_count_q <= '0;
        end else begin
            state_q     <= state_d;
            period_q    <= period_d;
            stop_pend_q <= stop_pend_d;
            if (start_acc) begin
                tick_count_q <= '0;
            end else if (tick) begin
                tick_count_q <= tick_count_q + 32'd1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        period_d      = period_q;
        stop_pend_d   = stop_pend_q;
        start_acc     = 1'b0;
        busy          = 1'b0;
        tick          = 1'b0;
        tm_address    = 3'd0;
        tm_chipselect = 1'b0;
        tm_write_n    = 1'b1;
        tm_writedata  = 16'h0000;
        unique case (state_q)
            StIdle: begin
                if (cfg_start) begin
                    start_acc   = 1'b1;
                    period_d    = (cfg_period == '0) ? PERIOD_DEFAULT : cfg_period;
                    stop_pend_d = 1'b0;
                    state_d     = StWrPl;
                end
            end
            StWrPl: begin
                busy          = 1'b1;
                tm_chipselect = 1'b1;
                tm_write_n    = 1'b0;
                tm_address    = 3'd2;
                tm_writedata  = period_q[15:0];
                state_d       = StWrPh;
            end
            StWrPh: begin
                busy          = 1'b1;
                tm_chipselect = 1'b1;
                tm_write_n    = 1'b0;
                tm_address    = 3'd3;
                tm_writedata  = period_q[31:16];
                state_d       = StWrCtl;
            end
            StWrCtl: begin
                busy          = 1'b1;
                tm_chipselect = 1'b1;
                tm_write_n    = 1'b0;
                tm_address    = 3'd1;
                tm_writedata  = 16'h0007;
                state_d       = StRun;
            end
            StRun: begin
                if (cfg_stop || stop_pend_q) begin
                    stop_pend_d = 1'b0;
                    state_d     = StWrStop;
                end else if (tm_irq) begin
                    state_d = StClr;
                end
            end
            StClr: begin
                tick          = 1'b1;
                tm_chipselect = 1'b1;
                tm_write_n    = 1'b0;
                if (cfg_stop) stop_pend_d = 1'b1;
                state_d = StGuard;
            end
            StGuard: begin
                // IRQ is still falling after the status clear; only a stop request is remembered
                if (cfg_stop) stop_pend_d = 1'b1;
                state_d = StRun;
            end
            StWrStop: begin
                busy          = 1'b1;
                tm_chipselect = 1'b1;
                tm_write_n    = 1'b0;
                tm_address    = 3'd1;
                tm_writedata  = 16'h0008;
                state_d       = StStopClr;
            end
            StStopClr: begin
                busy          = 1'b1;
                tm_chipselect = 1'b1;
                tm_write_n    = 1'b0;
                state_d       = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign running    = (state_q == StRun) || (state_q == StClr) || (state_q == StGuard);
    assign tick_count = tick_count_q;

    // A load on a tick cycle wins over the decrement for that channel
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
            active_q <= '0;
            expire_q <= '0;
        end else begin
            expire_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                if (ch_load[i]) begin
                    cnt_q[i]    <= ch_value;
                    active_q[i] <= |ch_value;
                end else if (tick && active_q[i]) begin
                    cnt_q[i] <= cnt_q[i] - CntOne;
                    if (cnt_q[i] == CntOne) begin
                        active_q[i] <= 1'b0;
                        expire_q[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign ch_active = active_q;
    assign ch_expire = expire_q;

endmodule

// File: doc/audio_timer_scheduler.md
# audio_timer_scheduler

Avalon-MM master sequencer that owns the system interval timer's s1 slave port. It programs the timer period, starts it in continuous interrupt mode, and services each timeout IRQ by clearing the status register. Each timeout becomes a one-cycle system `tick` that drives a free-running tick counter and NCH software-loadable countdown channels. Audio firmware and other fabric use it for periodic scheduling without touching timer registers.

## Interface
- PERIOD_DEFAULT, 32'd49999, period loaded when `cfg_period` is 0 (1 ms at 50 MHz)
- NCH, 4, number of countdown channels (1..8)
- CNT_W, 16, countdown channel width
- clk  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high reset
- cfg_start  in  1  pulse: program and start the timer (accepted only in IDLE)
- cfg_stop  in  1  pulse: stop the timer (accepted only in RUN)
- cfg_period  in  32  timer period minus one, sampled on accepted `cfg_start`
- busy  out  1  high while a register write sequence is in progress
- running  out  1  high in RUN, CLR and GUARD
- tm_address  out  3  timer register address
- tm_chipselect  out  1  timer chip select
- tm_write_n  out  1  timer write strobe, active low
- tm_writedata  out  16  timer write data
- tm_irq  in  1  timer interrupt, level
- tick  out  1  one-cycle pulse per serviced timeout
- tick_count  out  32  number of ticks since the last accepted start; wraps
- ch_load  in  NCH  per-channel load strobe
- ch_value  in  CNT_W  load value shared by all channels
- ch_active  out  NCH  channel counting
- ch_expire  out  NCH  one-cycle expiry pulse per channel

## Operation
- Every timer access is a single-cycle write: `tm_chipselect`=1, `tm_write_n`=0. There is no waitrequest and there are no reads.
- Idle bus state: `tm_chipselect`=0, `tm_write_n`=1, `tm_address`=0, `tm_writedata`=0.
- State machine states: IDLE, WR_PL, WR_PH, WR_CTL, RUN, CLR, GUARD, WR_STOP, STOP_CLR.
- IDLE + `cfg_start`: latch the period (`PERIOD_DEFAULT` if `cfg_period`==0), clear `tick_count`, go to WR_PL.
- WR_PL writes address 2 with period[15:0], then WR_PH.
- WR_PH writes address 3 with period[31:16], then WR_CTL.
- WR_CTL writes address 1 with 0x0007 (ITO, CONT, START), then RUN.
- RUN + `cfg_stop` goes to WR_STOP. `cfg_stop` has priority over `tm_irq`.
- RUN + `tm_irq` goes to CLR.
- CLR writes address 0 with 0x0000, asserts `tick`, increments `tick_count`, then GUARD.
- GUARD ignores `tm_irq` for one cycle while the timer deasserts it, then RUN. A `cfg_stop` arriving in CLR or GUARD is held pending and taken on return to RUN.
- WR_STOP writes address 1 with 0x0008 (STOP, ITO off), then STOP_CLR.
- STOP_CLR writes address 0 with 0x0000 to drop any pending timeout without a tick, then IDLE.
- `busy` = WR_PL, WR_PH, WR_CTL, WR_STOP or STOP_CLR. `cfg_start` outside IDLE and `cfg_stop` outside RUN/CLR/GUARD are ignored.
- Channel i, on `ch_load[i]`:
  - Counter = `ch_value`; `ch_active[i]` = (`ch_value`!=0). A load of 0 cancels the channel with no expiry.
  - A load always restarts an already active channel.
- Channel i, on `tick`: if active, decrement. On the 1->0 transition, clear `ch_active[i]` and assert `ch_expire[i]` the following cycle.
- Load on the same cycle as `tick` for the same channel: the load wins, with no decrement and no expiry.
- Channels keep their value while stopped; no ticks occur outside CLR.

## Timing
- Reset: state IDLE, bus idle, `busy`=0, `running`=0, `tick`=0, `tick_count`=0, `ch_active`=0, `ch_expire`=0, all counters 0.
- Start: accepted `cfg_start` at cycle N gives writes on N+1 (PL), N+2 (PH), N+3 (CTL), and `running`=1 from N+4.
- Service: `tm_irq` sampled high in RUN at cycle M gives the CLR write and `tick` at M+1, GUARD at M+2, RUN at M+3. Minimum tick spacing is 3 cycles.
- Expiry: `ch_expire` follows the terminal `tick` by 1 cycle.
- `tick_count` updates the cycle after `tick`, 32-bit wrap 0xFFFFFFFF->0.
- Reset asserted mid-sequence: the bus is idle the next cycle. No partial sequence is resumed.

## Test plan
- Reset check: assert `reset` 2 cycles -> every output at its reset value, bus idle.
- Program sequence: `cfg_period`=0x0001869F, pulse `cfg_start` -> consecutive writes (2,0x869F), (3,0x0001), (1,0x0007); `busy` high for 3 cycles, then `running`=1.
- Default period and IRQ service: start with `cfg_period`=0 -> writes (2,0xC34F), (3,0x0000). Hold `tm_irq` high 2 cycles from RUN -> exactly one (0,0x0000) write, one `tick`, `tick_count`=1.
- Channel expiry and collision: load ch1=3, issue 3 ticks -> `ch_expire[1]` one cycle after the 3rd tick, `ch_active[1]`=0. Load ch2=5 on a tick cycle -> ch2 still reads 5.
- Stop with pending IRQ: in RUN, assert `cfg_stop` and `tm_irq` on the same cycle -> writes (1,0x0008), (0,0x0000), no `tick`, return to IDLE.
- Reset mid-program: assert `reset` during WR_PH -> no CTL write, `busy`=0. A subsequent `cfg_start` replays the full 3-write sequence.
